top_io_frontend: RTL
====================

Name: top_io_frontend

Overview:
- Device-side endpoint of the byte-serial host protocol used by the AES/SHA3 Top.
- Receives two kinds of input frames, framed by i_start:
  - key frame: salt followed by password
  - message frame: one 128-bit block
- Hands each completed frame to the crypto core over wide valid/ready-style signals.
- Serializes the core's results back to the host: 16 cipher bytes, then 32 HMAC bytes.

Parameters:
SALT_BYTES, 16, salt length in bytes
PW_BYTES, 15, password length in bytes
BLK_BYTES, 16, message/cipher block length in bytes
MAC_BYTES, 32, HMAC length in bytes
TX_GAP, 2, idle cycles with o_valid low between cipher burst and MAC burst (min 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
i_data  in  8  host byte, sampled every cycle i_start=1
i_start  in  1  frame strobe, high for every byte of a frame
i_mode  in  1  operation mode, sampled on first key-frame byte
o_data  out  8  result byte
o_valid  out  1  high on every cycle o_data carries a result byte
o_ien  out  1  high while frontend/core busy; a falling edge tells the host it may send a message frame
o_key_valid  out  1  one-cycle pulse: o_salt/o_pw/o_mode valid
o_salt  out  SALT_BYTES*8  captured salt
o_pw  out  PW_BYTES*8  captured password
o_mode  out  1  latched mode
i_key_done  in  1  core finished key derivation (pulse)
o_msg_valid  out  1  one-cycle pulse: o_msg valid
o_msg  out  BLK_BYTES*8  captured message block
i_res_valid  in  1  core result ready (pulse); i_cipher/i_mac stable until o_res_ack
i_cipher  in  BLK_BYTES*8  cipher block
i_mac  in  MAC_BYTES*8  HMAC value
o_res_ack  out  1  one-cycle pulse after the last MAC byte is sent

Behaviour:
- Reset values: all outputs 0, all capture registers 0, FSM in IDLE. Reset mid-frame or mid-burst aborts immediately; the next cycle behaves as if just out of reset.
- Input byte order: MSB-first. The first byte received goes to bits [N*8-1 -: 8] of its field. Salt is received first, then password, in one continuous key frame.
- Output byte order: LSB-first. The first byte sent is bits [7:0].
- FSM:
  - IDLE (o_ien=0): i_start=1 captures byte 0 of salt and latches i_mode -> KEY_IN.
  - KEY_IN (o_ien=0): captures one byte per cycle while i_start=1. After byte SALT_BYTES+PW_BYTES-1 (31 total), next cycle o_key_valid=1 -> KEY_WAIT.
  - KEY_WAIT (o_ien=1): wait for i_key_done -> MSG_IDLE; o_ien falls on the following cycle.
  - MSG_IDLE (o_ien=0): i_start=1 captures msg byte 0 -> MSG_IN.
  - MSG_IN: after byte 15, next cycle o_msg_valid=1 -> CORE_WAIT.
  - CORE_WAIT (o_ien=1): i_res_valid latches i_cipher/i_mac into a shift register -> TX_CIPHER on the next cycle.
  - TX_CIPHER: o_valid=1 for exactly BLK_BYTES consecutive cycles -> GAP.
  - GAP: o_valid=0 for TX_GAP cycles -> TX_MAC.
  - TX_MAC: o_valid=1 for MAC_BYTES cycles. On the cycle after the last byte, o_res_ack=1 -> MSG_IDLE.
- o_ien:
  - 1 in KEY_WAIT, MSG_IN→CORE_WAIT, TX_*, GAP.
  - 0 in IDLE, KEY_IN, MSG_IDLE.
- o_data outside TX_CIPHER/TX_MAC: held at 0.
- Byte counter: 6 bits; resets to 0 on every state entry.
- Short frame (i_start falls before the byte count is reached): frame discarded, no valid pulse, counter cleared. Return to IDLE (key frame) or MSG_IDLE (message frame).
- Extra bytes (i_start still high after the count is reached), or i_start in any busy state: ignored.
- i_key_done or i_res_valid outside its wait state: ignored.
- o_salt, o_pw, o_mode, o_msg hold their values until the next frame of the same kind completes.
- Multiple messages per key: unlimited. A new key frame is accepted only after rst.

Optional Feature:
- Macro FRAME_CHECK_EN.
- When defined:
  - adds output o_err (1 bit, reset 0), sticky until rst;
  - o_err sets on a short frame, on extra bytes, or on i_start in a busy state;
  - while o_err=1, all new frames are ignored.
- When undefined: o_err does not exist; errors are handled silently as described in Behaviour.

Test Plan:
- Key load:
  - Stimulus: after rst, i_start=1 for 31 cycles; salt 00 01 … 0F, password 10 … 1E, i_mode=1.
  - Response: o_key_valid one cycle after the last byte; o_salt=0x000102…0F; o_pw=0x101112…1E; o_mode=1; o_ien=1 until one cycle after i_key_done.
- Message capture:
  - Stimulus: 16 bytes AA 00 … 00 0B with i_start.
  - Response: o_msg=0xAA00…000B; o_msg_valid one cycle after the last byte.
- Result burst:
  - Stimulus: i_res_valid with i_cipher=0x0F0E…00 and i_mac=0x1F1E…00 (32 bytes).
  - Response: o_data 00,01,…,0F on 16 cycles with o_valid=1; then 2 cycles o_valid=0; then 00…1F on 32 cycles; then o_res_ack pulse; then o_ien=0.
- Five messages in a row:
  - Stimulus: five message frames under one key, each sent after the corresponding o_ien fall.
  - Response: five cipher/MAC bursts in order; no dropped or merged bursts.
- Short frame:
  - Stimulus: i_start dropped after 10 message bytes.
  - Response: no o_msg_valid; a following full frame is accepted normally. With FRAME_CHECK_EN: o_err=1 and the following frame is ignored.
- Reset mid-burst:
  - Stimulus: rst asserted on the 5th MAC byte.
  - Response: next cycle o_valid=0, o_data=0, o_ien=0, FSM IDLE; a new key frame is accepted.

Source files
------------

// File: rtl/top_io_frontend.sv
// top_io_frontend: device-side endpoint of the byte-serial host protocol.
// Collects key frames (salt + password) and message frames from the host,
// hands them to the crypto core, and streams cipher then MAC bytes back.
// Optional build macro: FRAME_CHECK_EN adds a sticky o_err framing-error flag.
module top_io_frontend #(
    parameter int unsigned SALT_BYTES = 16,
    parameter int unsigned PW_BYTES   = 15,
    parameter int unsigned BLK_BYTES  = 16,
    parameter int unsigned MAC_BYTES  = 32,
    parameter int unsigned TX_GAP     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              i_data,
    input  logic                    i_start,
    input  logic                    i_mode,
    output logic [7:0]              o_data,
    output logic                    o_valid,
    output logic                    o_ien,
    output logic                    o_key_valid,
    output logic [SALT_BYTES*8-1:0] o_salt,
    output logic [PW_BYTES*8-1:0]   o_pw,
    output logic                    o_mode,
    input  logic                    i_key_done,
    output logic                    o_msg_valid,
    output logic [BLK_BYTES*8-1:0]  o_msg,
    input  logic                    i_res_valid,
    input  logic [BLK_BYTES*8-1:0]  i_cipher,
    input  logic [MAC_BYTES*8-1:0]  i_mac,
    output logic                    o_res_ack
`ifdef FRAME_CHECK_EN
    ,
    output logic                    o_err
`endif
);

    localparam int unsigned KEY_BYTES = SALT_BYTES + PW_BYTES;
    localparam int unsigned KEY_W     = KEY_BYTES * 8;
    localparam int unsigned SALT_W    = SALT_BYTES * 8;
    localparam int unsigned PW_W      = PW_BYTES * 8;
    localparam int unsigned BLK_W     = BLK_BYTES * 8;
    localparam int unsigned MAC_W     = MAC_BYTES * 8;

    // Byte 0 of each frame is taken in the idle state, so the counter in the
    // capture states runs one behind the byte index.
    localparam logic [5:0] KEY_LAST = 6'(KEY_BYTES - 2);
    localparam logic [5:0] MSG_LAST = 6'(BLK_BYTES - 2);
    localparam logic [5:0] CIP_LAST = 6'(BLK_BYTES - 1);
    localparam logic [5:0] GAP_LAST = 6'(TX_GAP - 1);
    localparam logic [5:0] MAC_LAST = 6'(MAC_BYTES - 1);

    typedef enum logic [3:0] {
        StIdle, StKeyIn, StKeyWait, StMsgIdle, StMsgIn,
        StCoreWait, StTxCipher, StGap, StTxMac
    } state_t;

    state_t              r_state;
    state_t              w_state_d;
    logic [5:0]          r_cnt;
    logic [KEY_W-1:0]    r_shift;
    logic [KEY_W-1:0]    w_shift_nxt;
    logic                r_mode_stage;
    logic [SALT_W-1:0]   r_salt;
    logic [PW_W-1:0]     r_pw;
    logic                r_mode;
    logic [BLK_W-1:0]    r_msg;
    logic                r_key_valid;
    logic                r_msg_valid;
    logic                r_res_ack;
    logic [BLK_W-1:0]    r_cipher;
    logic [MAC_W-1:0]    r_mac;

    logic w_accept;
    logic w_cap;
    logic w_mode_latch;
    logic w_key_done;
    logic w_msg_done;
    logic w_load_res;
    logic w_shift_cip;
    logic w_shift_mac;
    logic w_ack;
    logic w_busy;

`ifdef FRAME_CHECK_EN
    logic r_err;
    logic w_short;
    assign w_accept = i_start & ~r_err;
    assign o_err    = r_err;
`else
    assign w_accept = i_start;
`endif

    // MSB-first input: each new byte enters at the bottom and moves up.
    assign w_shift_nxt = {r_shift[KEY_W-9:0], i_data};

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_d    = r_state;
        w_cap        = 1'b0;
        w_mode_latch = 1'b0;
        w_key_done   = 1'b0;
        w_msg_done   = 1'b0;
        w_load_res   = 1'b0;
        w_shift_cip  = 1'b0;
        w_shift_mac  = 1'b0;
        w_ack        = 1'b0;
        w_busy       = 1'b0;
`ifdef FRAME_CHECK_EN
        w_short      = 1'b0;
`endif
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_cap        = 1'b1;
                    w_mode_latch = 1'b1;
                    w_state_d    = StKeyIn;
                end
            end
            StKeyIn: begin
                if (!i_start) begin
                    w_state_d = StIdle;
`ifdef FRAME_CHECK_EN
                    w_short   = 1'b1;
`endif
                end else begin
                    w_cap = 1'b1;
                    if (r_cnt == KEY_LAST) begin
                        w_key_done = 1'b1;
                        w_state_d  = StKeyWait;
                    end
                end
            end
            StKeyWait: begin
                w_busy = 1'b1;
                if (i_key_done) w_state_d = StMsgIdle;
            end
            StMsgIdle: begin
                if (w_accept) begin
                    w_cap     = 1'b1;
                    w_state_d = StMsgIn;
                end
            end
            StMsgIn: begin
                if (!i_start) begin
                    w_state_d = StMsgIdle;
`ifdef FRAME_CHECK_EN
                    w_short   = 1'b1;
`endif
                end else begin
                    w_cap = 1'b1;
                    if (r_cnt == MSG_LAST) begin
                        w_msg_done = 1'b1;
                        w_state_d  = StCoreWait;
                    end
                end
            end
            StCoreWait: begin
                w_busy = 1'b1;
                if (i_res_valid) begin
                    w_load_res = 1'b1;
                    w_state_d  = StTxCipher;
                end
            end
            StTxCipher: begin
                w_busy      = 1'b1;
                w_shift_cip = 1'b1;
                if (r_cnt == CIP_LAST) w_state_d = StGap;
            end
            StGap: begin
                w_busy = 1'b1;
                if (r_cnt == GAP_LAST) w_state_d = StTxMac;
            end
            StTxMac: begin
                w_busy      = 1'b1;
                w_shift_mac = 1'b1;
                if (r_cnt == MAC_LAST) begin
                    w_ack     = 1'b1;
                    w_state_d = StMsgIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State register; the byte counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= (w_state_d != r_state) ? 6'd0 : r_cnt + 6'd1;
        end
    end

    // Capture, hand-off and result shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_mode_stage <= 1'b0;
            r_salt       <= '0;
            r_pw         <= '0;
            r_mode       <= 1'b0;
            r_msg        <= '0;
            r_key_valid  <= 1'b0;
            r_msg_valid  <= 1'b0;
            r_res_ack    <= 1'b0;
            r_cipher     <= '0;
            r_mac        <= '0;
        end else begin
            r_key_valid <= w_key_done;
            r_msg_valid <= w_msg_done;
            r_res_ack   <= w_ack;
            if (w_cap) r_shift <= w_shift_nxt;
            if (w_mode_latch) r_mode_stage <= i_mode;
            // Published fields change only when a frame completes, so a
            // discarded short frame leaves the previous values intact.
            if (w_key_done) begin
                r_salt <= w_shift_nxt[KEY_W-1 -: SALT_W];
                r_pw   <= w_shift_nxt[PW_W-1:0];
                r_mode <= r_mode_stage;
            end
            if (w_msg_done) r_msg <= w_shift_nxt[BLK_W-1:0];
            if (w_load_res) begin
                r_cipher <= i_cipher;
                r_mac    <= i_mac;
            end else begin
                if (w_shift_cip) r_cipher <= {8'h00, r_cipher[BLK_W-1:8]};
                if (w_shift_mac) r_mac <= {8'h00, r_mac[MAC_W-1:8]};
            end
        end
    end

`ifdef FRAME_CHECK_EN
    // Sticky framing error: short frame or host traffic while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_short || (w_busy && i_start)) begin
            r_err <= 1'b1;
        end
    end
`endif

    // Host-facing result stream; LSB-first, zero whenever not transmitting.
    always_comb begin
        o_data  = 8'h00;
        o_valid = 1'b0;
        if (r_state == StTxCipher) begin
            o_data  = r_cipher[7:0];
            o_valid = 1'b1;
        end else if (r_state == StTxMac) begin
            o_data  = r_mac[7:0];
            o_valid = 1'b1;
        end
    end

    assign o_ien       = w_busy;
    assign o_key_valid = r_key_valid;
    assign o_salt      = r_salt;
    assign o_pw        = r_pw;
    assign o_mode      = r_mode;
    assign o_msg_valid = r_msg_valid;
    assign o_msg       = r_msg;
    assign o_res_ack   = r_res_ack;

endmodule
